// File: rtl/bsg_reduce_stream.sv
// Packet reducer: folds a 1-bit reduction of every accepted word into one result bit per packet.
// Define BSG_REDUCE_STREAM_PIPE_EN to register the per-word reduction (adds a FLUSH cycle).
module bsg_reduce_stream #(
   parameter int unsigned width_p     = 128,
   parameter int unsigned max_beats_p = 16
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic                               v_i,
   input  logic [width_p-1:0]                 data_i,
   input  logic                               last_i,
   input  logic [1:0]                         op_i,
   output logic                               ready_o,
   output logic                               v_o,
   output logic                               data_o,
   output logic [$clog2(max_beats_p+1)-1:0]   beats_o,
   output logic                               overflow_o,
   input  logic                               yumi_i
);

   localparam int unsigned BeatsW = $clog2(max_beats_p + 1);

`ifdef BSG_REDUCE_STREAM_PIPE_EN
   typedef enum logic [1:0] {StIdle = 2'd0, StAccum = 2'd1, StFlush = 2'd2, StDone = 2'd3} state_e;
`else
   typedef enum logic [1:0] {StIdle = 2'd0, StAccum = 2'd1, StDone = 2'd3} state_e;
`endif

   state_e              r_state;
   logic [1:0]          r_op;
   logic                r_acc;
   logic                r_data;
   logic                r_ovf;
   logic [BeatsW-1:0]   r_beats;

   logic                w_accept;
   logic                w_first;
   logic [1:0]          w_op;
   logic                w_bit;
   logic                w_fold;

`ifdef BSG_REDUCE_STREAM_PIPE_EN
   logic                r_bit;
   logic                r_bit_v;
   logic                r_bit_first;
`endif

   // xor and xnor both fold with XOR; xnor inverts only the final result
   function automatic logic f_fold(input logic a, input logic b, input logic [1:0] op);
      case (op)
         2'b01:   f_fold = a & b;
         2'b10:   f_fold = a | b;
         default: f_fold = a ^ b;
      endcase
   endfunction

   always_comb begin
      w_accept = v_i & ready_o;
      w_first  = (r_state == StIdle);
      w_op     = w_first ? op_i : r_op;
      case (w_op)
         2'b01:   w_bit = &data_i;
         2'b10:   w_bit = |data_i;
         default: w_bit = ^data_i;
      endcase
`ifdef BSG_REDUCE_STREAM_PIPE_EN
      w_fold = r_bit_first ? r_bit : f_fold(r_acc, r_bit, r_op);
`else
      w_fold = w_first ? w_bit : f_fold(r_acc, w_bit, r_op);
`endif
   end

   assign ready_o    = (r_state == StIdle) || (r_state == StAccum);
   assign v_o        = (r_state == StDone);
   assign data_o     = r_data;
   assign beats_o    = r_beats;
   assign overflow_o = r_ovf;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= StIdle;
         r_op        <= 2'b00;
         r_acc       <= 1'b0;
         r_data      <= 1'b0;
         r_ovf       <= 1'b0;
         r_beats     <= '0;
`ifdef BSG_REDUCE_STREAM_PIPE_EN
         r_bit       <= 1'b0;
         r_bit_v     <= 1'b0;
         r_bit_first <= 1'b0;
`endif
      end else begin
`ifdef BSG_REDUCE_STREAM_PIPE_EN
         // fold stage trails the accept stage by one cycle
         if (r_bit_v) r_acc <= w_fold;
         r_bit_v <= w_accept;
         if (w_accept) begin
            r_bit       <= w_bit;
            r_bit_first <= w_first;
         end
`endif
         case (r_state)
            StIdle, StAccum: begin
               if (w_accept) begin
                  if (w_first) r_op <= op_i;
                  if (r_beats == BeatsW'(max_beats_p)) r_ovf <= 1'b1;
                  else r_beats <= r_beats + 1'b1;
`ifdef BSG_REDUCE_STREAM_PIPE_EN
                  r_state <= last_i ? StFlush : StAccum;
`else
                  if (last_i) begin
                     r_data  <= w_fold ^ (w_op == 2'b11);
                     r_state <= StDone;
                  end else begin
                     r_acc   <= w_fold;
                     r_state <= StAccum;
                  end
`endif
               end
            end
`ifdef BSG_REDUCE_STREAM_PIPE_EN
            StFlush: begin
               r_data  <= w_fold ^ (r_op == 2'b11);
               r_state <= StDone;
            end
`endif
            StDone: begin
               if (yumi_i) begin
                  r_acc   <= 1'b0;
                  r_data  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_beats <= '0;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
